// File: rtl/driver_pkg.sv
// ============================================================================
// driver_pkg : shared defaults and types for the delayed-drive scheduler
// Revision   : 1.0
// ============================================================================
`default_nettype none

package driver_pkg;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_HOLD_W = 3;
    localparam int PTR_W      = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic                  vld;
        logic [DEF_DATA_W-1:0] dq;
    } drv_slot_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction
endpackage

`default_nettype wire

// File: rtl/driver_hold_ctr.sv
// ============================================================================
// driver_hold_ctr : emission register stage with programmable hold counter
// Revision        : 1.0
// ============================================================================
`default_nettype none

module driver_hold_ctr #(
    parameter int DATA_W = 8,
    parameter int HOLD_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              emit,
    input  logic [DATA_W-1:0] emit_dq,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              driv_valid,
    output logic [DATA_W-1:0] dq_out
);
    logic [HOLD_W-1:0] cnt;

    // A new emission always restarts the hold, even mid-hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            driv_valid <= 1'b0;
            dq_out     <= '0;
        end else if (emit) begin
            cnt        <= hold_len;
            driv_valid <= 1'b1;
            dq_out     <= emit_dq;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            driv_valid <= 1'b0;
            dq_out     <= '0;
        end
    end
endmodule

`default_nettype wire

// File: rtl/driver_sched.sv
// ============================================================================
// driver_sched : slot-indexed ring scheduler replaying drive requests after
//                a per-request delay. Optional stats: DRIVER_SCHED_STATS_EN
// Revision     : 1.0
// ============================================================================
`default_nettype none

module driver_sched
    import driver_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       driv,
    input  logic                       driv_shift,
    input  logic [$clog2(DEPTH)-1:0]   driv_front,
    input  logic [DATA_W-1:0]          dq_in,
    input  logic [HOLD_W-1:0]          hold_len,
    output logic                       driv_valid,
    output logic [DATA_W-1:0]          dq_in_delay,
    output logic [$clog2(DEPTH):0]     pend_cnt,
    output logic                       collision
`ifdef DRIVER_SCHED_STATS_EN
    ,
    output logic [15:0]                stat_issued,
    output logic [15:0]                stat_dropped
`endif
);
    localparam int SLOT_W = $clog2(DEPTH);
    localparam logic [SLOT_W:0] CNT_ONE = (SLOT_W+1)'(1);

    logic [DEPTH-1:0]  slot_vld;
    logic [DATA_W-1:0] slot_dq [DEPTH];
    logic [SLOT_W-1:0] ptr;

    logic              head_vld;
    logic              is_delayed;
    logic              is_imm;
    logic [SLOT_W-1:0] tgt;
    logic              accept;
    logic              drop;
    logic              emit;
    logic [DATA_W-1:0] emit_dq;

    // DEPTH is a power of two, so the target index wraps by plain truncation.
    always_comb begin
        head_vld   = slot_vld[ptr];
        is_delayed = driv && driv_shift && (driv_front != '0);
        is_imm     = driv && !is_delayed;
        tgt        = ptr + driv_front;
        accept     = is_delayed && !slot_vld[tgt];
        drop       = (is_delayed && slot_vld[tgt]) || (is_imm && head_vld);
        emit       = head_vld || is_imm;
        emit_dq    = head_vld ? slot_dq[ptr] : dq_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld  <= '0;
            ptr       <= '0;
            pend_cnt  <= '0;
            collision <= 1'b0;
        end else begin
            // tgt can never equal ptr because the delay is 1..DEPTH-1.
            if (head_vld) slot_vld[ptr] <= 1'b0;
            if (accept)   slot_vld[tgt] <= 1'b1;
            ptr       <= ptr + 1'b1;
            collision <= drop;
            case ({accept, head_vld})
                2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
                2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) slot_dq[tgt] <= dq_in;
    end

    driver_hold_ctr #(
        .DATA_W (DATA_W),
        .HOLD_W (HOLD_W)
    ) u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .emit       (emit),
        .emit_dq    (emit_dq),
        .hold_len   (hold_len),
        .driv_valid (driv_valid),
        .dq_out     (dq_in_delay)
    );

`ifdef DRIVER_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
        end else begin
            stat_issued  <= sat_inc16(stat_issued, emit);
            stat_dropped <= sat_inc16(stat_dropped, drop);
        end
    end
`endif
endmodule

`default_nettype wire

// File: tb/tb_driver_sched.sv
// ============================================================================
// tb_driver_sched : directed scenarios plus randomized traffic against an
//                   absolute-cycle reference model of driver_sched
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_driver_sched;
    localparam int DEPTH  = 32;
    localparam int DATA_W = 8;
    localparam int HOLD_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              driv = 1'b0;
    logic              driv_shift = 1'b0;
    logic [4:0]        driv_front = '0;
    logic [7:0]        dq_in = '0;
    logic [2:0]        hold_len = '0;
    logic              driv_valid;
    logic [7:0]        dq_in_delay;
    logic [5:0]        pend_cnt;
    logic              collision;
`ifdef DRIVER_SCHED_STATS_EN
    logic [15:0]       stat_issued;
    logic [15:0]       stat_dropped;
`endif

    driver_sched #(.DEPTH(DEPTH), .DATA_W(DATA_W), .HOLD_W(HOLD_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .driv        (driv),
        .driv_shift  (driv_shift),
        .driv_front  (driv_front),
        .dq_in       (dq_in),
        .hold_len    (hold_len),
        .driv_valid  (driv_valid),
        .dq_in_delay (dq_in_delay),
        .pend_cnt    (pend_cnt),
        .collision   (collision)
`ifdef DRIVER_SCHED_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_dropped(stat_dropped)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model in absolute cycle numbers: a pending request is keyed by
    // the cycle in which it is due; the active output is the latest emission.
    logic [7:0] pend [longint];
    longint     cyc = 0;
    bit         have_e = 0;
    longint     last_e = 0;
    int         last_h = 0;
    logic [7:0] last_dq = '0;
    bit         prev_drop = 0;
    int         m_issued = 0;
    int         m_dropped = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_update();
        bit         delayed, imm, emit, drop;
        logic [7:0] edq;
        delayed = driv && driv_shift && (driv_front != 0);
        imm     = driv && !delayed;
        emit = 0; drop = 0; edq = '0;
        if (pend.exists(cyc)) begin
            emit = 1; edq = pend[cyc]; pend.delete(cyc);
            if (imm) drop = 1;
        end else if (imm) begin
            emit = 1; edq = dq_in;
        end
        if (delayed) begin
            if (pend.exists(cyc + longint'(driv_front))) drop = 1;
            else pend[cyc + longint'(driv_front)] = dq_in;
        end
        if (emit) begin
            have_e = 1; last_e = cyc; last_h = int'(hold_len); last_dq = edq;
            m_issued++;
        end
        if (drop) m_dropped++;
        prev_drop = drop;
    endtask

    task automatic step(input logic d, input logic s, input logic [4:0] f,
                        input logic [7:0] q, input logic [2:0] h);
        bit exp_valid;
        @(posedge clk); #1;
        driv = d; driv_shift = s; driv_front = f; dq_in = q; hold_len = h;
        @(negedge clk);
        exp_valid = have_e && (cyc <= last_e + 1 + longint'(last_h));
        check("valid", driv_valid, exp_valid);
        check("dq", dq_in_delay, exp_valid ? last_dq : 8'h00);
        check("pend", pend_cnt, pend.num());
        check("coll", collision, prev_drop);
`ifdef DRIVER_SCHED_STATS_EN
        check("issued", stat_issued, m_issued);
        check("dropped", stat_dropped, m_dropped);
`endif
        model_update();
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        driv = 0; driv_shift = 0; driv_front = '0; dq_in = '0; hold_len = '0;
        @(negedge clk);
        check("rst_valid", driv_valid, 0);
        check("rst_dq", dq_in_delay, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_coll", collision, 0);
`ifdef DRIVER_SCHED_STATS_EN
        check("rst_issued", stat_issued, 0);
        check("rst_dropped", stat_dropped, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        pend.delete();
        have_e = 0; prev_drop = 0; m_issued = 0; m_dropped = 0; cyc = 0;
    endtask

    initial begin
        // Delayed request FRONT=5 at cycle 10 appears only in cycle 16.
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            step(c == 10, 1'b1, 5'd5, 8'hA5, 3'd0);
            check("s1_valid", driv_valid, c == 16);
            check("s1_pend", pend_cnt, (c >= 11 && c <= 15));
        end

        // Immediate requests with hold; second one replaces data and restarts hold.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            step(c == 4 || c == 6, 1'b0, 5'd0, (c == 4) ? 8'h3C : 8'h77, 3'd3);
            check("s2_dq", dq_in_delay,
                  (c >= 5 && c <= 6) ? 8'h3C : ((c >= 7 && c <= 10) ? 8'h77 : 8'h00));
        end

        // Two requests landing on the same slot: the first is kept.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            step(c == 0 || c == 2, 1'b1, (c == 0) ? 5'd7 : 5'd5,
                 (c == 0) ? 8'h11 : 8'h22, 3'd0);
            check("s3_coll", collision, c == 3);
            if (c == 8) check("s3_dq", dq_in_delay, 8'h11);
        end
`ifdef DRIVER_SCHED_STATS_EN
        check("s3_issued", stat_issued, 1);
        check("s3_dropped", stat_dropped, 1);
`endif

        // Fill 31 distinct slots with maximum delay, then drain.
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            step(c < 31, 1'b1, 5'd31, 8'(c + 1), 3'd0);
            if (c == 31) check("s4_full", pend_cnt, 31);
            check("s4_coll", collision, 0);
        end

        // Reset while a delayed request is in flight discards it.
        do_reset();
        for (int c = 0; c <= 4; c++) step(c == 3, 1'b1, 5'd4, 8'h5A, 3'd0);
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            step(1'b0, 1'b0, 5'd0, 8'h00, 3'd0);
            check("s5_valid", driv_valid, 0);
            check("s5_pend", pend_cnt, 0);
        end

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom_range(1)), ($urandom_range(9) < 7),
                 5'($urandom_range(31)), 8'($urandom), 3'($urandom_range(7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
